// File: rtl/dm_4k.sv
// dm_4k: 1024 x 32 data memory, combinational read, synchronous write.
// Build option DM_BYTE_WRITE_EN adds per-byte write strobes (port be).
module dm_4k #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  we,
`ifdef DM_BYTE_WRITE_EN
  input  logic [3:0]            be,
`endif
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rst
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic                  run;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;

  // Writes are held off for the edge on which reset releases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // Only a clean logic 1 on we may write.
  always_comb begin
    wr = 1'b0;
    if (we && run) wr = 1'b1;
  end

`ifdef DM_BYTE_WRITE_EN
  // Merge enabled byte lanes of din into the current word.
  always_comb begin
    wdata = mem[addr];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wdata[b*8 +: 8] = din[b*8 +: 8];
    end
  end
`else
  // Full-word write.
  always_comb begin
    wdata = din;
  end
`endif

  // Storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[addr] <= wdata;
    end
  end

  // Combinational read, no write-through bypass.
  always_comb begin
    dout = mem[addr];
  end

endmodule

// File: tb/tb_dm_4k.sv
// tb_dm_4k: directed checks for dm_4k.
// Inputs change on negedge; outputs sampled off the rising edge.
module tb_dm_4k;

  logic [9:0]  addr;
  logic [31:0] din;
  logic        we;
  logic        clk;
  logic [31:0] dout;
  logic        rst;
`ifdef DM_BYTE_WRITE_EN
  logic [3:0]  be;
`endif

  int checks;
  int failures;

  dm_4k dut (
    .addr (addr),
    .din  (din),
    .we   (we),
`ifdef DM_BYTE_WRITE_EN
    .be   (be),
`endif
    .clk  (clk),
    .dout (dout),
    .rst  (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    addr = a;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    we   = 1'b0;
    addr = 10'd1;
    din  = 32'h0;
`ifdef DM_BYTE_WRITE_EN
    be = 4'hF;
`endif
    #30;
    check("rst_hold_dout", dout, 32'h0);
    we  = 1'b1;
    din = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("rst_blocks_wr", dout, 32'h0);
    we = 1'b0;
    #(120 - $time);
    rst = 1'b1;
    rd(10'd1);
    check("post_rst_a1", dout, 32'h0);
    rd(10'd2);
    check("post_rst_a2", dout, 32'h0);

    wr(10'd1, 32'h1);
    check("wr_a1", dout, 32'h1);
    wr(10'd2, 32'h67);
    rd(10'd1);
    check("rd_a1", dout, 32'h1);
    rd(10'd2);
    check("rd_a2", dout, 32'h67);

    @(negedge clk);
    addr = 10'd1;
    din  = 32'h3;
    we   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("we0_block", dout, 32'h1);

    @(negedge clk);
    addr = 10'd5;
    din  = 32'hAAAA_5555;
    we   = 1'b1;
    #1;
    check("rdw_old", dout, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("rdw_new", dout, 32'hAAAA_5555);

    addr = 10'd2;
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_a2", dout, 32'h0);
    rd(10'd1);
    check("async_rst_a1", dout, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd(10'd2);
    check("rel_a2", dout, 32'h0);
    rd(10'd5);
    check("rel_a5", dout, 32'h0);

    wr(10'h3FF, 32'hDEAD_BEEF);
    wr(10'h000, 32'h1234_5678);
    rd(10'h3FF);
    check("rd_3ff", dout, 32'hDEAD_BEEF);
    rd(10'h000);
    check("rd_000", dout, 32'h1234_5678);
    rd(10'h1FF);
    check("rd_1ff", dout, 32'h0);
    rd(10'h200);
    check("rd_200", dout, 32'h0);

`ifdef DM_BYTE_WRITE_EN
    be = 4'b0011;
    wr(10'h000, 32'hFFFF_FFFF);
    check("be_0011", dout, 32'h1234_FFFF);
    be = 4'b1000;
    wr(10'h3FF, 32'h0000_0000);
    check("be_1000", dout, 32'h00AD_BEEF);
    be = 4'hF;
`endif

    wr(10'h3FF, 32'hCAFE_F00D);
    rd(10'h000);
`ifdef DM_BYTE_WRITE_EN
    check("no_alias_0", dout, 32'h1234_FFFF);
`else
    check("no_alias_0", dout, 32'h1234_5678);
`endif
    rd(10'h3FF);
    check("rewr_3ff", dout, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
